// File: rtl/counter_seq_pkg.sv
// Shared types and default widths for the counter sequencer.
package counter_seq_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WRAP_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [CNT_W-1:0]  load;
        logic [CNT_W-1:0]  mod;
        logic [WRAP_W-1:0] wraps;
    } seq_cmd_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command valid/ready channel between the host and the counter sequencer.
interface counter_sequencer_if
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W,
    parameter int unsigned WRAPW = WRAP_W
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_load;
    logic [WIDTH-1:0] cmd_mod;
    logic [WRAPW-1:0] cmd_wraps;

    modport master (
        output cmd_valid, cmd_load, cmd_mod, cmd_wraps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_mod, cmd_wraps,
        output cmd_ready
    );

endinterface

// File: rtl/counter_seq_cmd_check.sv
// Command legality: the modulus must be at least 2 and the start value below it.
module counter_seq_cmd_check #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] load,
    input  logic [WIDTH-1:0] mod,
    output logic             legal
);

    assign legal = (mod >= WIDTH'(2)) && (load < mod);

endmodule

// File: rtl/counter_sequencer.sv
// Programs a loadable modulo counter and runs it for a requested number of wraps.
// Define COUNTER_SEQ_QUEUE_EN to add a one-entry pending-command register.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W,
    parameter int unsigned WRAPW = WRAP_W
) (
    input  logic               clk,
    input  logic               rst,
    counter_sequencer_if.slave cmd,
    input  logic               abort,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_load_value,
    output logic [WIDTH-1:0]   cnt_mod_value,
    input  logic [WIDTH-1:0]   cnt_count,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WRAPW-1:0]   wraps_seen
);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] load_q, mod_q, next_load, next_mod;
    logic [WRAPW-1:0] cmd_wraps_q, wraps_q, wraps_inc, next_wraps;
    logic             err_q;
    logic             legal, accept, active, wrap_hit, final_wrap, launch;

    counter_seq_cmd_check #(.WIDTH(WIDTH)) u_check (
        .load  (cmd.cmd_load),
        .mod   (cmd.cmd_mod),
        .legal (legal)
    );

    assign accept     = cmd.cmd_valid & cmd.cmd_ready;
    assign active     = (state_q == LOAD) || (state_q == RUN);
    assign wraps_inc  = (&wraps_q) ? wraps_q : wraps_q + WRAPW'(1);
    assign wrap_hit   = (state_q == RUN) && (cnt_count == mod_q - WIDTH'(1));
    assign final_wrap = wrap_hit && (wraps_inc == cmd_wraps_q);

`ifdef COUNTER_SEQ_QUEUE_EN
    logic             pend_valid_q, pend_valid_d, use_pend;
    logic [WIDTH-1:0] pend_load_q, pend_mod_q;
    logic [WRAPW-1:0] pend_wraps_q;

    always_comb begin
        pend_valid_d = pend_valid_q;
        if (use_pend)                       pend_valid_d = 1'b0;
        if (accept && legal && active)      pend_valid_d = 1'b1;
        // abort drops both the running and the pending command
        if (abort && active)                pend_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_load_q  <= '0;
            pend_mod_q   <= '0;
            pend_wraps_q <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            if (accept && legal && active) begin
                pend_load_q  <= cmd.cmd_load;
                pend_mod_q   <= cmd.cmd_mod;
                pend_wraps_q <= cmd.cmd_wraps;
            end
        end
    end

    assign next_load  = use_pend ? pend_load_q  : cmd.cmd_load;
    assign next_mod   = use_pend ? pend_mod_q   : cmd.cmd_mod;
    assign next_wraps = use_pend ? pend_wraps_q : cmd.cmd_wraps;
`else
    assign next_load  = cmd.cmd_load;
    assign next_mod   = cmd.cmd_mod;
    assign next_wraps = cmd.cmd_wraps;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
`ifdef COUNTER_SEQ_QUEUE_EN
        use_pend = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept && legal) begin
                    launch  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort)                  state_d = IDLE;
                else if (cmd_wraps_q == '0) state_d = DONE;
                else                        state_d = RUN;
            end
            RUN: begin
                if (abort)           state_d = IDLE;
                else if (final_wrap) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
`ifdef COUNTER_SEQ_QUEUE_EN
                if (pend_valid_q) begin
                    launch   = 1'b1;
                    use_pend = 1'b1;
                    state_d  = LOAD;
                end else if (accept && legal) begin
                    launch  = 1'b1;
                    state_d = LOAD;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_load = (state_q == LOAD);
        busy     = active;
        done     = (state_q == DONE);
`ifdef COUNTER_SEQ_QUEUE_EN
        cmd.cmd_ready = !pend_valid_q;
`else
        cmd.cmd_ready = (state_q == IDLE);
`endif
    end

    // Counter programming values persist after completion; the counter free-runs on them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q       <= 1'b0;
            load_q      <= '0;
            mod_q       <= '0;
            cmd_wraps_q <= '0;
            wraps_q     <= '0;
        end else begin
            err_q <= accept && !legal;
            if (launch) begin
                load_q      <= next_load;
                mod_q       <= next_mod;
                cmd_wraps_q <= next_wraps;
                wraps_q     <= '0;
            end else if (wrap_hit && !abort) begin
                wraps_q <= wraps_inc;
            end
        end
    end

    assign cnt_load_value = load_q;
    assign cnt_mod_value  = mod_q;
    assign err            = err_q;
    assign wraps_seen     = wraps_q;

endmodule
